// File: rtl/exu_div_wakeup_unit.sv
// -----------------------------------------------------------------------------
// exu_div_wakeup_unit
//
// Iterative 64-bit integer divider for the execute stage. One DIV/DIVU/REM/REMU
// op is accepted at a time. The result is produced by a radix-2 restoring
// divider. The unit also drives the div1/div2/div3 wakeup broadcasts that let
// issue-queue entries speculatively wake up ahead of the writeback.
//
// Timing (issue accepted in cycle T):
//   T+1        PREP  : take magnitudes, record signs, flag special cases
//   T+2..T+65  CALC  : one quotient bit per cycle (div1 wakeup in T+65)
//   T+66       FIX   : sign correction and special-case override (div2)
//   T+67       DONE  : writeback and div3 result broadcast
//   T+68             : ready again
//
// Optional feature (macro KS_DIV_SPECIAL_FASTPATH_EN):
//   Divide-by-zero and signed overflow skip CALC (PREP->FIX), so div1 is in
//   T+1, div2 in T+2, and div3/writeback in T+3. Results are unchanged.
//
// Ports:
//   clk, rst_clk                   clock, asynchronous active-high reset
//   rtu_global_flush               kills the in-flight op, gates all vld outs
//   idu_exu_div_*                  issue request: vld, iid, funct3, operands,
//                                  destination preg and its valid
//   exu_idu_div_ready              unit idle, may accept an issue
//   exu_idu_is_div1_forward_*      wakeup, result due in 2 cycles
//   exu_idu_is_div2_forward_*      wakeup, result due next cycle
//   exu_idu_is_div3_result_*       result-cycle broadcast
//   exu_div_result_*               writeback: vld, iid, pdst_vld, pdst, data
// -----------------------------------------------------------------------------
module exu_div_wakeup_unit #(
   parameter int XLEN   = 64,
   parameter int PREG_W = 6,
   parameter int IID_W  = 4
) (
   input  logic              clk,
   input  logic              rst_clk,
   input  logic              rtu_global_flush,
   input  logic              idu_exu_div_issue_vld,
   input  logic [IID_W-1:0]  idu_exu_div_iid,
   input  logic [2:0]        idu_exu_div_funct3,
   input  logic [XLEN-1:0]   idu_exu_div_src1,
   input  logic [XLEN-1:0]   idu_exu_div_src2,
   input  logic              idu_exu_div_pdst_vld,
   input  logic [PREG_W-1:0] idu_exu_div_pdst,
   output logic              exu_idu_div_ready,
   output logic              exu_idu_is_div1_forward_vld,
   output logic [PREG_W-1:0] exu_idu_is_div1_forward_preg,
   output logic              exu_idu_is_div2_forward_vld,
   output logic [PREG_W-1:0] exu_idu_is_div2_forward_preg,
   output logic              exu_idu_is_div3_result_vld,
   output logic [PREG_W-1:0] exu_idu_is_div3_result_preg,
   output logic              exu_div_result_vld,
   output logic [IID_W-1:0]  exu_div_result_iid,
   output logic              exu_div_result_pdst_vld,
   output logic [PREG_W-1:0] exu_div_result_pdst,
   output logic [XLEN-1:0]   exu_div_result_data
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } state_t;

   // Divide-by-zero: divisor is zero, regardless of signedness.
   function automatic logic f_is_dbz(input logic [XLEN-1:0] src2);
      return src2 == '0;
   endfunction

   // Signed overflow: most-negative dividend divided by -1.
   function automatic logic f_is_ovf(input logic [XLEN-1:0] src1,
                                     input logic [XLEN-1:0] src2,
                                     input logic            is_signed);
      return is_signed && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
   endfunction

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ready;

   logic [IID_W-1:0]  r_iid;
   logic              r_is_rem;
   logic              r_is_unsigned;
   logic              r_pdst_vld;
   logic [PREG_W-1:0] r_pdst;
   logic [XLEN-1:0]   r_src1;
   logic [XLEN-1:0]   r_src2;

   logic [XLEN-1:0]   r_q;        // dividend bits shift out, quotient bits shift in
   logic [XLEN-1:0]   r_rem;      // partial remainder
   logic [XLEN-1:0]   r_divisor;  // divisor magnitude
   logic              r_q_neg;
   logic              r_r_neg;
   logic              r_dbz;
   logic              r_ovf;
   logic [XLEN-1:0]   r_result;

   logic              r_div1;
   logic              r_div2;
   logic              r_div3;
   logic              r_res_vld;

   // funct3[2] is always 1 for the div group and carries no information here.
   logic              w_unused_funct3;
   assign w_unused_funct3 = idu_exu_div_funct3[2];

   // ---------------------------------------------------------------------------
   // PREP: operand magnitudes
   // ---------------------------------------------------------------------------
   logic            w_signed;
   logic [XLEN-1:0] w_abs1;
   logic [XLEN-1:0] w_abs2;

   assign w_signed = !r_is_unsigned;
   // Negating the most-negative value yields the same bit pattern, which read
   // as unsigned is exactly its magnitude.
   assign w_abs1   = (w_signed && r_src1[XLEN-1]) ? -r_src1 : r_src1;
   assign w_abs2   = (w_signed && r_src2[XLEN-1]) ? -r_src2 : r_src2;

   // ---------------------------------------------------------------------------
   // CALC: one restoring step
   // ---------------------------------------------------------------------------
   logic [XLEN:0]   w_rem_sh;
   logic [XLEN:0]   w_rem_sub;
   logic            w_ge;

   // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
   assign w_rem_sh  = {r_rem, r_q[XLEN-1]};
   assign w_rem_sub = w_rem_sh - {1'b0, r_divisor};
   assign w_ge      = (w_rem_sh >= {1'b0, r_divisor});

   // ---------------------------------------------------------------------------
   // FIX: sign correction, special-case override, rem/quot select
   // ---------------------------------------------------------------------------
   logic [XLEN-1:0] w_fix_quot;
   logic [XLEN-1:0] w_fix_rem;
   logic [XLEN-1:0] w_fix_data;

   // NOTE: every variable assigned in an always_comb gets a value on every path
   // (defaults first); otherwise synthesis infers a latch.
   always_comb begin
      w_fix_quot = r_q_neg ? -r_q : r_q;
      w_fix_rem  = r_r_neg ? -r_rem : r_rem;
      if (r_dbz) begin
         w_fix_quot = '1;
         w_fix_rem  = r_src1;
      end else if (r_ovf) begin
         w_fix_quot = r_src1;
         w_fix_rem  = '0;
      end
      w_fix_data = r_is_rem ? w_fix_rem : w_fix_quot;
   end

`ifdef KS_DIV_SPECIAL_FASTPATH_EN
   // Special case detected on the raw issue operands so the div1 wakeup can be
   // registered into PREP itself.
   logic w_in_special;
   assign w_in_special = f_is_dbz(idu_exu_div_src2) ||
                         f_is_ovf(idu_exu_div_src1, idu_exu_div_src2,
                                  !idu_exu_div_funct3[0]);
`endif

   // ---------------------------------------------------------------------------
   // FSM with registered wakeup/result flags
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   // NOTE: the whole datapath is reset, not only control; the reset state is
   // observable as all-zero outputs and a flush must leave the same state.
   always_ff @(posedge clk or posedge rst_clk) begin
      if (rst_clk) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_ready       <= 1'b1;
         r_iid         <= '0;
         r_is_rem      <= 1'b0;
         r_is_unsigned <= 1'b0;
         r_pdst_vld    <= 1'b0;
         r_pdst        <= '0;
         r_src1        <= '0;
         r_src2        <= '0;
         r_q           <= '0;
         r_rem         <= '0;
         r_divisor     <= '0;
         r_q_neg       <= 1'b0;
         r_r_neg       <= 1'b0;
         r_dbz         <= 1'b0;
         r_ovf         <= 1'b0;
         r_result      <= '0;
         r_div1        <= 1'b0;
         r_div2        <= 1'b0;
         r_div3        <= 1'b0;
         r_res_vld     <= 1'b0;
      end else if (rtu_global_flush) begin
         // Flush kills any in-flight op and drops a same-cycle issue.
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_ready       <= 1'b1;
         r_iid         <= '0;
         r_is_rem      <= 1'b0;
         r_is_unsigned <= 1'b0;
         r_pdst_vld    <= 1'b0;
         r_pdst        <= '0;
         r_src1        <= '0;
         r_src2        <= '0;
         r_q           <= '0;
         r_rem         <= '0;
         r_divisor     <= '0;
         r_q_neg       <= 1'b0;
         r_r_neg       <= 1'b0;
         r_dbz         <= 1'b0;
         r_ovf         <= 1'b0;
         r_result      <= '0;
         r_div1        <= 1'b0;
         r_div2        <= 1'b0;
         r_div3        <= 1'b0;
         r_res_vld     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (idu_exu_div_issue_vld) begin
                  r_iid         <= idu_exu_div_iid;
                  r_is_rem      <= idu_exu_div_funct3[1];
                  r_is_unsigned <= idu_exu_div_funct3[0];
                  r_pdst_vld    <= idu_exu_div_pdst_vld;
                  r_pdst        <= idu_exu_div_pdst_vld ? idu_exu_div_pdst : '0;
                  r_src1        <= idu_exu_div_src1;
                  r_src2        <= idu_exu_div_src2;
                  r_ready       <= 1'b0;
                  r_state       <= ST_PREP;
`ifdef KS_DIV_SPECIAL_FASTPATH_EN
                  r_div1        <= idu_exu_div_pdst_vld && w_in_special;
`endif
               end
            end

            ST_PREP: begin
               r_q       <= w_abs1;
               r_divisor <= w_abs2;
               r_rem     <= '0;
               r_q_neg   <= w_signed && (r_src1[XLEN-1] ^ r_src2[XLEN-1]);
               r_r_neg   <= w_signed && r_src1[XLEN-1];
               r_dbz     <= f_is_dbz(r_src2);
               r_ovf     <= f_is_ovf(r_src1, r_src2, w_signed);
               r_cnt     <= CNT_LAST;
               r_div1    <= 1'b0;
`ifdef KS_DIV_SPECIAL_FASTPATH_EN
               if (f_is_dbz(r_src2) || f_is_ovf(r_src1, r_src2, w_signed)) begin
                  r_div2  <= r_pdst_vld;
                  r_state <= ST_FIX;
               end else begin
                  r_state <= ST_CALC;
               end
`else
               r_state   <= ST_CALC;
`endif
            end

            ST_CALC: begin
               r_q   <= {r_q[XLEN-2:0], w_ge};
               r_rem <= w_ge ? w_rem_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
               r_cnt <= r_cnt - 1'b1;
               // div1 is registered one step early so it lands in the last CALC cycle.
               r_div1 <= r_pdst_vld && (r_cnt == CNT_W'(1));
               if (r_cnt == '0) begin
                  r_div2  <= r_pdst_vld;
                  r_state <= ST_FIX;
               end
            end

            ST_FIX: begin
               r_result  <= w_fix_data;
               r_div2    <= 1'b0;
               r_div3    <= r_pdst_vld;
               r_res_vld <= 1'b1;
               r_state   <= ST_DONE;
            end

            ST_DONE: begin
               r_div3    <= 1'b0;
               r_res_vld <= 1'b0;
               r_ready   <= 1'b1;
               r_state   <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: flush masks every broadcast in the cycle it is asserted.
   // ---------------------------------------------------------------------------
   logic w_div1_vld;
   logic w_div2_vld;
   logic w_div3_vld;
   logic w_res_vld;

   assign w_div1_vld = r_div1    && !rtu_global_flush;
   assign w_div2_vld = r_div2    && !rtu_global_flush;
   assign w_div3_vld = r_div3    && !rtu_global_flush;
   assign w_res_vld  = r_res_vld && !rtu_global_flush;

   assign exu_idu_div_ready            = r_ready;
   assign exu_idu_is_div1_forward_vld  = w_div1_vld;
   assign exu_idu_is_div1_forward_preg = w_div1_vld ? r_pdst : '0;
   assign exu_idu_is_div2_forward_vld  = w_div2_vld;
   assign exu_idu_is_div2_forward_preg = w_div2_vld ? r_pdst : '0;
   assign exu_idu_is_div3_result_vld   = w_div3_vld;
   assign exu_idu_is_div3_result_preg  = w_div3_vld ? r_pdst : '0;

   assign exu_div_result_vld      = w_res_vld;
   assign exu_div_result_iid      = w_res_vld ? r_iid : '0;
   assign exu_div_result_pdst_vld = w_res_vld && r_pdst_vld;
   assign exu_div_result_pdst     = w_res_vld ? r_pdst : '0;
   assign exu_div_result_data     = w_res_vld ? r_result : '0;

endmodule

// File: tb/tb_exu_div_wakeup_unit.sv
// -----------------------------------------------------------------------------
// tb_exu_div_wakeup_unit
//
// Directed vectors for exu_div_wakeup_unit with hand-computed quotients and
// remainders. Each op records the cycle (relative to the issue cycle T) at
// which every wakeup/result valid first appears, and compares it against the
// expected schedule, optionally truncated by a flush.
// -----------------------------------------------------------------------------
module tb_exu_div_wakeup_unit;

   localparam int XLEN   = 64;
   localparam int PREG_W = 6;
   localparam int IID_W  = 4;
   localparam int NO_FLUSH = 1000;

   localparam logic [XLEN-1:0] MIN  = 64'h8000_0000_0000_0000;
   localparam logic [XLEN-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

`ifdef KS_DIV_SPECIAL_FASTPATH_EN
   localparam bit FASTPATH = 1'b1;
`else
   localparam bit FASTPATH = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_clk;
   logic              rtu_global_flush;
   logic              idu_exu_div_issue_vld;
   logic [IID_W-1:0]  idu_exu_div_iid;
   logic [2:0]        idu_exu_div_funct3;
   logic [XLEN-1:0]   idu_exu_div_src1;
   logic [XLEN-1:0]   idu_exu_div_src2;
   logic              idu_exu_div_pdst_vld;
   logic [PREG_W-1:0] idu_exu_div_pdst;
   logic              exu_idu_div_ready;
   logic              exu_idu_is_div1_forward_vld;
   logic [PREG_W-1:0] exu_idu_is_div1_forward_preg;
   logic              exu_idu_is_div2_forward_vld;
   logic [PREG_W-1:0] exu_idu_is_div2_forward_preg;
   logic              exu_idu_is_div3_result_vld;
   logic [PREG_W-1:0] exu_idu_is_div3_result_preg;
   logic              exu_div_result_vld;
   logic [IID_W-1:0]  exu_div_result_iid;
   logic              exu_div_result_pdst_vld;
   logic [PREG_W-1:0] exu_div_result_pdst;
   logic [XLEN-1:0]   exu_div_result_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   exu_div_wakeup_unit #(
      .XLEN   (XLEN),
      .PREG_W (PREG_W),
      .IID_W  (IID_W)
   ) u_dut (
      .clk                          (clk),
      .rst_clk                      (rst_clk),
      .rtu_global_flush             (rtu_global_flush),
      .idu_exu_div_issue_vld        (idu_exu_div_issue_vld),
      .idu_exu_div_iid              (idu_exu_div_iid),
      .idu_exu_div_funct3           (idu_exu_div_funct3),
      .idu_exu_div_src1             (idu_exu_div_src1),
      .idu_exu_div_src2             (idu_exu_div_src2),
      .idu_exu_div_pdst_vld         (idu_exu_div_pdst_vld),
      .idu_exu_div_pdst             (idu_exu_div_pdst),
      .exu_idu_div_ready            (exu_idu_div_ready),
      .exu_idu_is_div1_forward_vld  (exu_idu_is_div1_forward_vld),
      .exu_idu_is_div1_forward_preg (exu_idu_is_div1_forward_preg),
      .exu_idu_is_div2_forward_vld  (exu_idu_is_div2_forward_vld),
      .exu_idu_is_div2_forward_preg (exu_idu_is_div2_forward_preg),
      .exu_idu_is_div3_result_vld   (exu_idu_is_div3_result_vld),
      .exu_idu_is_div3_result_preg  (exu_idu_is_div3_result_preg),
      .exu_div_result_vld           (exu_div_result_vld),
      .exu_div_result_iid           (exu_div_result_iid),
      .exu_div_result_pdst_vld      (exu_div_result_pdst_vld),
      .exu_div_result_pdst          (exu_div_result_pdst),
      .exu_div_result_data          (exu_div_result_data)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Cycles from issue (T) to the DONE cycle.
   function automatic int op_latency(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
      logic special;
      special = (b == 64'd0) || (!f3[0] && (a == MIN) && (b == ONES));
      return (FASTPATH && special) ? 3 : 67;
   endfunction

   function automatic logic [3:0] vld_bus();
      return {exu_idu_is_div1_forward_vld, exu_idu_is_div2_forward_vld,
              exu_idu_is_div3_result_vld, exu_div_result_vld};
   endfunction

   // Issue one op and observe it until the cycle it should be ready again.
   // fa = cycle offset from T at which flush is asserted for one cycle
   // (0 = same cycle as the issue, NO_FLUSH = never).
   task automatic run_op(input string name, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic pvld, input logic [PREG_W-1:0] pdst,
                         input logic [IID_W-1:0] iid, input logic [63:0] exp_data,
                         input int fa);
      int lat, e1, e2, e3, er, erdy, ew;
      int c1, c2, c3, cr, crdy, nwake, w;
      logic [PREG_W-1:0] p1, p2, p3, rpd, exp_pdst;
      logic [IID_W-1:0]  riid;
      logic              rpv;
      logic [63:0]       rdata;

      lat  = op_latency(f3, a, b);
      e1   = (pvld && (lat - 2 < fa)) ? lat - 2 : -1;
      e2   = (pvld && (lat - 1 < fa)) ? lat - 1 : -1;
      e3   = (pvld && (lat < fa)) ? lat : -1;
      er   = (lat < fa) ? lat : -1;
      erdy = (fa <= lat) ? fa + 1 : lat + 1;
      ew   = (e1 >= 0 ? 1 : 0) + (e2 >= 0 ? 1 : 0) + (e3 >= 0 ? 1 : 0);
      exp_pdst = pvld ? pdst : '0;
      c1 = -1; c2 = -1; c3 = -1; cr = -1; crdy = -1; nwake = 0;
      p1 = '0; p2 = '0; p3 = '0; rpd = '0; riid = '0; rpv = 1'b0; rdata = '0;

      @(negedge clk);
      check({name, ".ready_pre"}, 64'(exu_idu_div_ready), 64'd1);
      idu_exu_div_issue_vld = 1'b1;
      idu_exu_div_funct3    = f3;
      idu_exu_div_src1      = a;
      idu_exu_div_src2      = b;
      idu_exu_div_pdst_vld  = pvld;
      idu_exu_div_pdst      = pdst;
      idu_exu_div_iid       = iid;
      rtu_global_flush      = (fa == 0);
      @(posedge clk);
      #1;
      idu_exu_div_issue_vld = 1'b0;
      rtu_global_flush      = 1'b0;
      idu_exu_div_src1      = 64'hDEAD_BEEF_0BAD_F00D;
      idu_exu_div_src2      = 64'h0123_4567_89AB_CDEF;
      idu_exu_div_pdst      = '1;
      idu_exu_div_iid       = '1;

      for (int k = 1; k <= erdy; k++) begin
         @(negedge clk);
         if (k == fa) rtu_global_flush = 1'b1;
         #1;
         if (exu_idu_is_div1_forward_vld) begin
            nwake++;
            if (c1 < 0) begin c1 = k; p1 = exu_idu_is_div1_forward_preg; end
         end
         if (exu_idu_is_div2_forward_vld) begin
            nwake++;
            if (c2 < 0) begin c2 = k; p2 = exu_idu_is_div2_forward_preg; end
         end
         if (exu_idu_is_div3_result_vld) begin
            nwake++;
            if (c3 < 0) begin c3 = k; p3 = exu_idu_is_div3_result_preg; end
         end
         if (exu_div_result_vld && cr < 0) begin
            cr    = k;
            rdata = exu_div_result_data;
            riid  = exu_div_result_iid;
            rpv   = exu_div_result_pdst_vld;
            rpd   = exu_div_result_pdst;
         end
         if (exu_idu_div_ready && crdy < 0) crdy = k;
         if (rtu_global_flush) begin
            @(posedge clk);
            #1;
            rtu_global_flush = 1'b0;
         end
      end

      check({name, ".div1_cycle"},  64'(c1),    64'(e1));
      check({name, ".div2_cycle"},  64'(c2),    64'(e2));
      check({name, ".div3_cycle"},  64'(c3),    64'(e3));
      check({name, ".result_cycle"}, 64'(cr),   64'(er));
      check({name, ".wake_pulses"}, 64'(nwake), 64'(ew));
      check({name, ".ready_cycle"}, 64'(crdy),  64'(erdy));
      if (e1 >= 0) check({name, ".div1_preg"}, 64'(p1), 64'(exp_pdst));
      if (e2 >= 0) check({name, ".div2_preg"}, 64'(p2), 64'(exp_pdst));
      if (e3 >= 0) check({name, ".div3_preg"}, 64'(p3), 64'(exp_pdst));
      if (er >= 0) begin
         check({name, ".data"},      rdata,     exp_data);
         check({name, ".iid"},       64'(riid), 64'(iid));
         check({name, ".pdst_vld"},  64'(rpv),  64'(pvld));
         check({name, ".pdst"},      64'(rpd),  64'(exp_pdst));
      end

      // Bounded resynchronisation so one failure does not cascade into a hang.
      w = 0;
      while (!exu_idu_div_ready && w < 100) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (!exu_idu_div_ready) check({name, ".drain_ready"}, 64'd0, 64'd1);
   endtask

   initial begin
      int n_busy, n_pulse;

      rst_clk               = 1'b1;
      rtu_global_flush      = 1'b0;
      idu_exu_div_issue_vld = 1'b0;
      idu_exu_div_iid       = '0;
      idu_exu_div_funct3    = '0;
      idu_exu_div_src1      = '0;
      idu_exu_div_src2      = '0;
      idu_exu_div_pdst_vld  = 1'b0;
      idu_exu_div_pdst      = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("reset.ready", 64'(exu_idu_div_ready), 64'd1);
      check("reset.vlds",  64'(vld_bus()), 64'd0);
      check("reset.pregs", 64'({exu_idu_is_div1_forward_preg, exu_idu_is_div2_forward_preg,
                                exu_idu_is_div3_result_preg, exu_div_result_pdst}), 64'd0);
      check("reset.result", exu_div_result_data, 64'd0);
      check("reset.iid_pv", 64'({exu_div_result_iid, exu_div_result_pdst_vld}), 64'd0);
      @(negedge clk);
      rst_clk = 1'b0;

      // Main function                  f3      src1                    src2                    pv    pdst   iid    expected
      run_op("divu_100_7",   3'b101, 64'd100,                64'd7,                  1'b1, 6'h15, 4'd3, 64'd14,                  NO_FLUSH);
      run_op("remu_100_7",   3'b111, 64'd100,                64'd7,                  1'b1, 6'h2A, 4'd4, 64'd2,                   NO_FLUSH);
      run_op("rem_m100_7",   3'b110, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                 1'b1, 6'h01, 4'd5, 64'hFFFF_FFFF_FFFF_FFFE, NO_FLUSH);
      run_op("div_m100_7",   3'b100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                 1'b1, 6'h3F, 4'd6, 64'hFFFF_FFFF_FFFF_FFF2, NO_FLUSH);
      run_op("div_7_m2",     3'b100, 64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 6'h0C, 4'd8, 64'hFFFF_FFFF_FFFF_FFFD, NO_FLUSH);
      run_op("rem_7_m2",     3'b110, 64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 6'h0D, 4'd9, 64'd1,                   NO_FLUSH);
      run_op("divu_big",     3'b101, ONES,                   64'h1_0000_0000,        1'b1, 6'h22, 4'd10, 64'hFFFF_FFFF,           NO_FLUSH);
      // Divide by zero and signed overflow
      run_op("div_5_0",      3'b100, 64'd5,                  64'd0,                  1'b1, 6'h07, 4'd7, ONES,                    NO_FLUSH);
      run_op("remu_5_0",     3'b111, 64'd5,                  64'd0,                  1'b1, 6'h08, 4'd11, 64'd5,                  NO_FLUSH);
      run_op("rem_m7_0",     3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0,                 1'b1, 6'h09, 4'd12, 64'hFFFF_FFFF_FFFF_FFF9, NO_FLUSH);
      run_op("div_ovf",      3'b100, MIN,                    ONES,                   1'b1, 6'h10, 4'd13, MIN,                    NO_FLUSH);
      run_op("rem_ovf",      3'b110, MIN,                    ONES,                   1'b1, 6'h11, 4'd14, 64'd0,                  NO_FLUSH);
      // Same operands unsigned: ordinary division, no special case
      run_op("divu_min_ones", 3'b101, MIN,                   ONES,                   1'b1, 6'h12, 4'd15, 64'd0,                  NO_FLUSH);
      run_op("remu_min_ones", 3'b111, MIN,                   ONES,                   1'b1, 6'h13, 4'd1, MIN,                     NO_FLUSH);
      // No destination register: writeback still happens, no wakeups
      run_op("nopdst",       3'b101, 64'd100,                64'd7,                  1'b0, 6'h15, 4'd2, 64'd14,                  NO_FLUSH);
      // Flush at FIX, at DONE, mid-CALC and together with the issue
      run_op("flush_fix",    3'b101, 64'd1000,               64'd10,                 1'b1, 6'h19, 4'd3, 64'd100,                 66);
      run_op("flush_done",   3'b101, 64'd1000,               64'd10,                 1'b1, 6'h1A, 4'd4, 64'd100,                 67);
      run_op("flush_calc",   3'b100, 64'd1000,               64'd10,                 1'b1, 6'h1B, 4'd5, 64'd100,                 30);
      run_op("flush_issue",  3'b101, 64'd1000,               64'd10,                 1'b1, 6'h1C, 4'd6, 64'd100,                 0);
      // The unit must be fully usable after a flush
      run_op("after_flush",  3'b100, 64'd1000,               64'd10,                 1'b1, 6'h1D, 4'd7, 64'd100,                 NO_FLUSH);

      // Asynchronous reset in the middle of CALC
      @(negedge clk);
      idu_exu_div_issue_vld = 1'b1;
      idu_exu_div_funct3    = 3'b101;
      idu_exu_div_src1      = 64'd100;
      idu_exu_div_src2      = 64'd7;
      idu_exu_div_pdst_vld  = 1'b1;
      idu_exu_div_pdst      = 6'h15;
      @(posedge clk);
      #1;
      idu_exu_div_issue_vld = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("midrst.busy", 64'(exu_idu_div_ready), 64'd0);
      #2;
      rst_clk = 1'b1;
      #1;
      check("midrst.ready_now", 64'(exu_idu_div_ready), 64'd1);
      check("midrst.vlds_now",  64'(vld_bus()), 64'd0);
      @(negedge clk);
      rst_clk = 1'b0;
      n_busy  = 0;
      n_pulse = 0;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         #1;
         if (!exu_idu_div_ready) n_busy++;
         if (vld_bus() != 4'd0) n_pulse++;
      end
      check("midrst.no_busy",  64'(n_busy),  64'd0);
      check("midrst.no_pulse", 64'(n_pulse), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
